alu_pipe: RTL and testbench

- Parametrised, registered successor to the 6502 core's combinational ALU.
- Operand A is selected from NARGS register-file inputs. Operand B is data_in.
- Computes the full 6502 arithmetic/logic/shift set and produces a status-register image.
- Results are held in an output register behind a valid/ready handshake, so the sequencer can stall and issue back-to-back ops.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_bcd_adj.sv | 57 +++++
 rtl/alu_pipe.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined 6502-style ALU.
//   - 4-bit operation codes OP_INC .. OP_BIT (14 and 15 are undefined ops).
//   - Status register bit positions (N V - B D I Z C).
//   - FSM state type used by alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_INC = 4'd0;
  localparam logic [3:0] OP_DEC = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_ORA = 4'd5;
  localparam logic [3:0] OP_EOR = 4'd6;
  localparam logic [3:0] OP_ASL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_TST = 4'd12;
  localparam logic [3:0] OP_BIT = 4'd13;

  localparam int SR_N = 7;
  localparam int SR_V = 6;
  localparam int SR_D = 3;
  localparam int SR_Z = 1;
  localparam int SR_C = 0;

  // ST_ADJ is only ever entered when decimal mode is compiled in.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ADJ  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_bcd_adj.sv
// alu_bcd_adj: combinational per-nibble BCD add/subtract.
//   Recomputes the operation nibble by nibble with decimal correction
//   (+6 on a nibble above 9 for add, -6 on a nibble borrow for subtract).
// Ports:
//   a_i, b_i    WIDTH-bit BCD operands (WIDTH must be a multiple of 4)
//   carry_i     6502 carry in (for subtract, 1 means "no borrow")
//   sub_i       1 = subtract (SBC), 0 = add (ADC)
//   result_o    BCD-corrected result
//   carry_o     decimal carry out (subtract: 1 means no borrow)
module alu_bcd_adj
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  localparam int NIB = WIDTH / 4;

  logic [4:0] nib;
  logic       c;

  always_comb begin
    result_o = '0;
    nib      = '0;
    // For subtract the chain carries a borrow, the inverse of the 6502 carry.
    c        = sub_i ? ~carry_i : carry_i;
    for (int i = 0; i < NIB; i++) begin
      if (!sub_i) begin
        nib = {1'b0, a_i[i*4 +: 4]} + {1'b0, b_i[i*4 +: 4]} + {4'b0000, c};
        if (nib > 5'd9) begin
          nib = nib + 5'd6;
          c   = 1'b1;
        end else begin
          c   = 1'b0;
        end
      end else begin
        // Bit 4 going high signals the nibble went negative.
        nib = {1'b0, a_i[i*4 +: 4]} - {1'b0, b_i[i*4 +: 4]} - {4'b0000, c};
        if (nib[4]) begin
          nib = nib - 5'd6;
          c   = 1'b1;
        end else begin
          c   = 1'b0;
        end
      end
      result_o[i*4 +: 4] = nib[3:0];
    end
    carry_o = sub_i ? ~c : c;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered 6502-style ALU with valid/ready handshakes.
//   Operand A is one of NARGS register-file sources picked by arg_sel
//   (out-of-range selects source 0); operand B is data_in. The result and
//   a full status-register image are held in an output register.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. out_valid, once high, holds result_out and
// sr_out stable until out_ready takes them. in_ready depends combinationally
// on out_ready so a pop and a push can share one edge (full throughput).
//
// Optional feature, macro ALU_PIPE_DECIMAL_EN: ADC/SBC issued with the D
// flag set spend one extra cycle in state ST_ADJ for BCD correction
// (latency 2, in_ready low during ST_ADJ). N, V, Z come from the binary
// result, C from the decimal carry. Without the macro D is ignored.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   op, arg_sel, args     operation code, operand-A index, flattened sources
//   data_in, sr_in        operand B, current status register
//   out_valid / out_ready output handshake
//   result_out, sr_out    registered result and status image
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NARGS = 4,
  parameter int SEL_W = $clog2(NARGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic [SEL_W-1:0]       arg_sel,
  input  logic [NARGS*WIDTH-1:0] args,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [7:0]             sr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result_out,
  output logic [7:0]             sr_out
);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       sr_q, sr_d;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_r;
  logic [7:0]       alu_sr;
  logic             set_nz;
  logic             cin;
  logic             accept;
  logic             go_adj;

  assign cin      = sr_in[SR_C];
  assign in_ready = reset_n & (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Operand A mux; indices with no matching source fall back to source 0.
  always_comb begin
    a_op = args[WIDTH-1:0];
    for (int i = 1; i < NARGS; i++) begin
      if (int'(arg_sel) == i) a_op = args[i*WIDTH +: WIDTH];
    end
  end

  // SBC is ADC with B inverted; CMP is always a borrow-free subtract.
  assign bx   = (op == OP_SBC) ? ~data_in : data_in;
  assign sum  = {1'b0, a_op} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a_op} + {1'b0, ~data_in} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_r  = a_op;
    alu_sr = sr_in;
    set_nz = 1'b0;
    case (op)
      OP_INC: begin
        alu_r  = a_op + WIDTH'(1);
        set_nz = 1'b1;
      end
      OP_DEC: begin
        alu_r  = a_op - WIDTH'(1);
        set_nz = 1'b1;
      end
      OP_ADC, OP_SBC: begin
        alu_r        = sum[WIDTH-1:0];
        alu_sr[SR_C] = sum[WIDTH];
        alu_sr[SR_V] = (a_op[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a_op[WIDTH-1]);
        set_nz       = 1'b1;
      end
      OP_AND: begin
        alu_r  = a_op & data_in;
        set_nz = 1'b1;
      end
      OP_ORA: begin
        alu_r  = a_op | data_in;
        set_nz = 1'b1;
      end
      OP_EOR: begin
        alu_r  = a_op ^ data_in;
        set_nz = 1'b1;
      end
      OP_ASL: begin
        alu_r        = {a_op[WIDTH-2:0], 1'b0};
        alu_sr[SR_C] = a_op[WIDTH-1];
        set_nz       = 1'b1;
      end
      OP_LSR: begin
        alu_r        = {1'b0, a_op[WIDTH-1:1]};
        alu_sr[SR_C] = a_op[0];
        set_nz       = 1'b1;
      end
      OP_ROL: begin
        alu_r        = {a_op[WIDTH-2:0], cin};
        alu_sr[SR_C] = a_op[WIDTH-1];
        set_nz       = 1'b1;
      end
      OP_ROR: begin
        alu_r        = {cin, a_op[WIDTH-1:1]};
        alu_sr[SR_C] = a_op[0];
        set_nz       = 1'b1;
      end
      OP_CMP: begin
        alu_r        = a_op;
        alu_sr[SR_N] = diff[WIDTH-1];
        alu_sr[SR_Z] = (diff[WIDTH-1:0] == '0);
        alu_sr[SR_C] = diff[WIDTH];
      end
      OP_TST: begin
        alu_r  = data_in;
        set_nz = 1'b1;
      end
      OP_BIT: begin
        alu_r        = a_op;
        alu_sr[SR_Z] = ((a_op & data_in) == '0);
        alu_sr[SR_N] = data_in[WIDTH-1];
        alu_sr[SR_V] = data_in[WIDTH-2];
      end
      default: begin
        alu_r        = '1;
        alu_sr[SR_V] = 1'b0;
        alu_sr[SR_C] = 1'b0;
      end
    endcase
    if (set_nz) begin
      alu_sr[SR_N] = alu_r[WIDTH-1];
      alu_sr[SR_Z] = (alu_r == '0);
    end
  end

`ifdef ALU_PIPE_DECIMAL_EN
  // Operands and binary flags are captured at accept; ST_ADJ finishes the op
  // from these so the input bus is free while the correction runs.
  logic [WIDTH-1:0] dec_a_q, dec_b_q;
  logic             dec_cin_q, dec_sub_q;
  logic [7:0]       dec_sr_q;
  logic [WIDTH-1:0] bcd_r;
  logic             bcd_c;

  assign go_adj = sr_in[SR_D] & ((op == OP_ADC) | (op == OP_SBC));

  alu_bcd_adj #(.WIDTH(WIDTH)) u_bcd_adj (
    .a_i      (dec_a_q),
    .b_i      (dec_b_q),
    .carry_i  (dec_cin_q),
    .sub_i    (dec_sub_q),
    .result_o (bcd_r),
    .carry_o  (bcd_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_a_q   <= '0;
      dec_b_q   <= '0;
      dec_cin_q <= 1'b0;
      dec_sub_q <= 1'b0;
      dec_sr_q  <= 8'h00;
    end else if (accept && go_adj) begin
      dec_a_q   <= a_op;
      dec_b_q   <= data_in;
      dec_cin_q <= cin;
      dec_sub_q <= (op == OP_SBC);
      dec_sr_q  <= alu_sr;
    end
  end
`else
  assign go_adj = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sr_d        = sr_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (go_adj) begin
            state_d = ST_ADJ;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_r;
            sr_d        = alu_sr;
          end
        end
      end
      ST_ADJ: begin
        state_d = ST_IDLE;
`ifdef ALU_PIPE_DECIMAL_EN
        // The output register was empty or being popped when this op was
        // accepted, so it is free to load here.
        out_valid_d = 1'b1;
        result_d    = bcd_r;
        sr_d        = {dec_sr_q[7:1], bcd_c};
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sr_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sr_q        <= sr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result_out = result_q;
  assign sr_out     = sr_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe (WIDTH=8, NARGS=4).
// Decimal-mode sequences are compiled in when ALU_PIPE_DECIMAL_EN is defined.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int NA = 4;
  localparam int SW = 2;
  localparam int NV = 21;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [SW-1:0]   arg_sel;
  logic [NA*W-1:0] args;
  logic [W-1:0]    data_in;
  logic [7:0]      sr_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result_out;
  logic [7:0]      sr_out;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   sr;
    logic [W-1:0] exp_r;
    logic [7:0]   exp_sr;
  } vec_t;

  vec_t         vecs[NV];
  logic [W+7:0] exp_q[$];
  logic [W+7:0] sb_e;
  int           n_cmp = 0;
  int           n_fail = 0;
  time          t0;

  alu_pipe #(.WIDTH(W), .NARGS(NA)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .arg_sel    (arg_sel),
    .args       (args),
    .data_in    (data_in),
    .sr_in      (sr_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .sr_out     (sr_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted op pushes its expected {result, sr}; every
  // output transfer pops and compares. Sampled on the falling edge ahead of
  // the rising edge where the transfer happens.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h required no output", {result_out, sr_out});
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_output", {result_out, sr_out}, sb_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [3:0] o, input int sel, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [7:0] sr);
    op      = o;
    arg_sel = sel[SW-1:0];
    data_in = b;
    sr_in   = sr;
    for (int i = 0; i < NA; i++) args[i*W +: W] = (i == sel) ? a : (~a ^ W'(i));
  endtask

  // Called and returns at posedge+1; returns one step after the accepting edge
  // with in_valid still high.
  task automatic issue(input logic [3:0] o, input int sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [7:0] sr,
                       input logic [W-1:0] er, input logic [7:0] esr);
    int tries;
    tries = 0;
    set_inputs(o, sel, a, b, sr);
    in_valid = 1'b1;
    #1;
    while (!in_ready && tries < 20) begin
      @(posedge clk);
      #2;
      tries++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 required 1 within 20 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({er, esr});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{OP_ADC, 8'h50, 8'h50, 8'h24, 8'hA0, 8'hE4};
    vecs[1]  = '{OP_INC, 8'hFF, 8'h00, 8'h25, 8'h00, 8'h27};
    vecs[2]  = '{OP_SBC, 8'h00, 8'h01, 8'h25, 8'hFF, 8'hA4};
    vecs[3]  = '{OP_DEC, 8'h00, 8'h00, 8'h03, 8'hFF, 8'h81};
    vecs[4]  = '{OP_ROR, 8'h01, 8'h00, 8'h25, 8'h80, 8'hA5};
    vecs[5]  = '{OP_CMP, 8'h10, 8'h20, 8'h27, 8'h10, 8'hA4};
    vecs[6]  = '{OP_AND, 8'hF0, 8'h0F, 8'h80, 8'h00, 8'h02};
    vecs[7]  = '{OP_ORA, 8'hF0, 8'h0F, 8'h42, 8'hFF, 8'hC0};
    vecs[8]  = '{OP_EOR, 8'hAA, 8'hFF, 8'h83, 8'h55, 8'h01};
    vecs[9]  = '{OP_ASL, 8'h81, 8'h00, 8'h00, 8'h02, 8'h01};
    vecs[10] = '{OP_LSR, 8'h01, 8'h00, 8'h80, 8'h00, 8'h03};
    vecs[11] = '{OP_ROL, 8'h80, 8'h00, 8'h83, 8'h01, 8'h01};
    vecs[12] = '{OP_ADC, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h41};
    vecs[13] = '{OP_TST, 8'h55, 8'h00, 8'h80, 8'h00, 8'h02};
    vecs[14] = '{OP_BIT, 8'h0F, 8'hC0, 8'h00, 8'h0F, 8'hC2};
    vecs[15] = '{OP_BIT, 8'hFF, 8'h01, 8'hC2, 8'hFF, 8'h00};
    vecs[16] = '{4'd14,  8'h12, 8'h34, 8'hC1, 8'hFF, 8'h80};
    vecs[17] = '{4'd15,  8'h00, 8'h00, 8'hBD, 8'hFF, 8'hBC};
    vecs[18] = '{OP_ADC, 8'h3F, 8'h40, 8'h01, 8'h80, 8'hC0};
    vecs[19] = '{OP_CMP, 8'h42, 8'h42, 8'h80, 8'h42, 8'h03};
    vecs[20] = '{OP_SBC, 8'h50, 8'hB0, 8'h01, 8'hA0, 8'hC0};

    // Reset state.
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_inputs(OP_INC, 0, 8'h00, 8'h00, 8'h00);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result_out, 0);
    check("rst_sr", sr_out, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Table vectors, one op per two cycles, latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, i % NA, vecs[i].a, vecs[i].b, vecs[i].sr, vecs[i].exp_r, vecs[i].exp_sr);
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_result", i), result_out, vecs[i].exp_r);
      check($sformatf("v%0d_sr", i), sr_out, vecs[i].exp_sr);
      cycles(1);
    end
    check("idle_out_valid", out_valid, 0);

    // Backpressure: result held, next op stalled, then pop+push on one edge.
    out_ready = 1'b0;
    issue(OP_INC, 1, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00);
    set_inputs(OP_DEC, 2, 8'h10, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_result", k), result_out, 8'h02);
      cycles(1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    exp_q.push_back({8'h0F, 8'h00});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", result_out, 8'h0F);
    cycles(1);
    check("bp_drained_valid", out_valid, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Back-to-back: four ops on four consecutive edges.
    t0 = $time;
    issue(OP_ADC, 0, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00);
    issue(OP_EOR, 1, 8'h0F, 8'hFF, 8'h00, 8'hF0, 8'h80);
    issue(OP_LSR, 2, 8'h02, 8'h00, 8'h01, 8'h01, 8'h00);
    issue(OP_TST, 3, 8'h00, 8'h80, 8'h02, 8'h80, 8'h80);
    in_valid = 1'b0;
    check("b2b_elapsed", 32'($time - t0), 40);
    cycles(2);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Reset while a result is waiting.
    out_ready = 1'b0;
    issue(OP_INC, 0, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h80);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result_out, 0);
    check("midrst_sr", sr_out, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    cycles(1);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    issue(OP_DEC, 3, 8'h01, 8'h00, 8'h01, 8'h00, 8'h03);
    in_valid = 1'b0;
    check("after_rst_result", result_out, 8'h00);
    check("after_rst_sr", sr_out, 8'h03);
    cycles(1);

`ifdef ALU_PIPE_DECIMAL_EN
    // Decimal ADC: two-cycle latency, in_ready low while adjusting.
    issue(OP_ADC, 0, 8'h19, 8'h28, 8'h08, 8'h47, 8'h08);
    in_valid = 1'b0;
    check("dec1_adj_in_ready", in_ready, 0);
    check("dec1_adj_out_valid", out_valid, 0);
    cycles(1);
    check("dec1_valid", out_valid, 1);
    check("dec1_result", result_out, 8'h47);
    check("dec1_sr", sr_out, 8'h08);
    check("dec1_in_ready", in_ready, 1);
    cycles(1);

    issue(OP_ADC, 1, 8'h99, 8'h01, 8'h08, 8'h00, 8'h89);
    in_valid = 1'b0;
    cycles(1);
    check("dec2_result", result_out, 8'h00);
    check("dec2_sr", sr_out, 8'h89);
    cycles(1);

    issue(OP_SBC, 2, 8'h00, 8'h01, 8'h09, 8'h99, 8'h88);
    in_valid = 1'b0;
    cycles(1);
    check("dec3_result", result_out, 8'h99);
    check("dec3_sr", sr_out, 8'h88);
    cycles(1);

    // Reset while adjusting discards the op.
    issue(OP_ADC, 0, 8'h45, 8'h45, 8'h08, 8'h90, 8'hC8);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("adjrst_out_valid", out_valid, 0);
    check("adjrst_sr", sr_out, 0);
    exp_q.delete();
    cycles(1);
    reset_n = 1'b1;
    cycles(2);
    check("adjrst_no_output", out_valid, 0);
    issue(OP_INC, 0, 8'h41, 8'h00, 8'h00, 8'h42, 8'h00);
    in_valid = 1'b0;
    check("adjrst_next_valid", out_valid, 1);
    check("adjrst_next_result", result_out, 8'h42);
    cycles(1);
`endif

    cycles(2);
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
